// File: rtl/led_pkg.sv
// Shared types and constants for the LED pattern generator.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_CHASE  = 2'd0,
        MODE_BOUNCE = 2'd1,
        MODE_BLINK  = 2'd2,
        MODE_COUNT  = 2'd3
    } led_mode_t;

    // LED pins are active-low
    localparam logic LED_OFF = 1'b1;

endpackage

// File: rtl/led_step_tick.sv
// Step-period counter: counts 0..STEP_CYCLES-1 while enabled and flags the last cycle.
module led_step_tick #(
    parameter int unsigned STEP_CYCLES = 12_000_000,
    parameter int unsigned CNT_W       = 30
) (
    input  logic CLK_IN,
    input  logic RST_N,
    input  logic EN,
    output logic tick
);

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(STEP_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick = EN && (cnt_q == CntMax);

    always_comb begin
        cnt_d = cnt_q;
        if (EN) begin
            cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK_IN or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_pattern_gen.sv
// Active-low LED bank pattern generator (chase/bounce/blink/count).
// Define LED_PWM_EN to add the BRIGHT input and registered PWM dimming.
module led_pattern_gen
    import led_pkg::*;
#(
    parameter int unsigned N_LED       = 3,
    parameter int unsigned STEP_CYCLES = 12_000_000,
    parameter int unsigned CNT_W       = 30,
    parameter int unsigned PWM_W       = 8
) (
    input  logic             CLK_IN,
    input  logic             RST_N,
    input  logic             EN,
    input  logic [1:0]       MODE,
    input  logic             DIR,
`ifdef LED_PWM_EN
    input  logic [PWM_W-1:0] BRIGHT,
`endif
    output logic [N_LED-1:0] LED_OUT,
    output logic             STEP_PULSE
);

    localparam int unsigned POS_W = $clog2(N_LED + 1);
    localparam logic [POS_W-1:0] PosBlank = POS_W'(N_LED);
    localparam logic [POS_W-1:0] PosLast  = POS_W'(N_LED - 1);

    if (N_LED < 1 || N_LED > 32 || STEP_CYCLES < 2 || PWM_W < 1
        || $clog2(STEP_CYCLES) > CNT_W) begin : g_bad_param
        $error("led_pattern_gen: illegal parameter combination");
    end

    logic             tick;
    led_mode_t        mode_sel;
    led_mode_t        mode_q, mode_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             up_q, up_d;
    logic             blink_q, blink_d;
    logic [N_LED-1:0] val_q, val_d;
    logic [N_LED-1:0] pat_q, pat_d;
    logic             pulse_q;

    led_step_tick #(
        .STEP_CYCLES (STEP_CYCLES),
        .CNT_W       (CNT_W)
    ) u_step_tick (
        .CLK_IN (CLK_IN),
        .RST_N  (RST_N),
        .EN     (EN),
        .tick   (tick)
    );

    assign mode_sel = led_mode_t'(MODE);

    always_comb begin
        mode_d  = mode_q;
        pos_d   = pos_q;
        up_d    = up_q;
        blink_d = blink_q;
        val_d   = val_q;
        if (tick) begin
            if (mode_sel != mode_q) begin
                mode_d = mode_sel;
                unique case (mode_sel)
                    MODE_CHASE:  pos_d = DIR ? PosLast : '0;
                    MODE_BOUNCE: begin
                        pos_d = '0;
                        up_d  = 1'b1;
                    end
                    MODE_BLINK:  blink_d = 1'b1;
                    MODE_COUNT:  val_d = '0;
                endcase
            end else begin
                unique case (mode_q)
                    MODE_CHASE: begin
                        // Ring of N_LED+1 slots; PosBlank is the all-off slot
                        if (!DIR) begin
                            pos_d = (pos_q >= PosBlank) ? '0 : pos_q + POS_W'(1);
                        end else if (pos_q >= PosBlank) begin
                            pos_d = PosLast;
                        end else if (pos_q == '0) begin
                            pos_d = PosBlank;
                        end else begin
                            pos_d = pos_q - POS_W'(1);
                        end
                    end
                    MODE_BOUNCE: begin
                        if (N_LED == 1) begin
                            pos_d = '0;
                        end else if (up_q) begin
                            if (pos_q >= PosLast) begin
                                pos_d = pos_q - POS_W'(1);
                                up_d  = 1'b0;
                            end else begin
                                pos_d = pos_q + POS_W'(1);
                            end
                        end else if (pos_q == '0) begin
                            pos_d = POS_W'(1);
                            up_d  = 1'b1;
                        end else begin
                            pos_d = pos_q - POS_W'(1);
                        end
                    end
                    MODE_BLINK:  blink_d = ~blink_q;
                    MODE_COUNT:  val_d = val_q + N_LED'(1);
                endcase
            end
        end
    end

    always_comb begin
        pat_d = {N_LED{LED_OFF}};
        unique case (mode_d)
            MODE_CHASE, MODE_BOUNCE: begin
                for (int i = 0; i < N_LED; i++) begin
                    if (pos_d == POS_W'(i)) pat_d[i] = ~LED_OFF;
                end
            end
            MODE_BLINK:  if (blink_d) pat_d = {N_LED{~LED_OFF}};
            MODE_COUNT:  pat_d = ~val_d;
        endcase
    end

    always_ff @(posedge CLK_IN or negedge RST_N) begin
        if (!RST_N) begin
            mode_q  <= MODE_CHASE;
            pos_q   <= PosBlank;
            up_q    <= 1'b1;
            blink_q <= 1'b1;
            val_q   <= '0;
            pat_q   <= {N_LED{LED_OFF}};
            pulse_q <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            pos_q   <= pos_d;
            up_q    <= up_d;
            blink_q <= blink_d;
            val_q   <= val_d;
            pat_q   <= pat_d;
            pulse_q <= tick;
        end
    end

`ifdef LED_PWM_EN
    logic [PWM_W-1:0] pwm_q;
    logic [N_LED-1:0] out_q;
    logic             pulse_dly_q;

    always_ff @(posedge CLK_IN or negedge RST_N) begin
        if (!RST_N) begin
            pwm_q       <= '0;
            out_q       <= {N_LED{LED_OFF}};
            pulse_dly_q <= 1'b0;
        end else begin
            pwm_q       <= pwm_q + PWM_W'(1);
            out_q       <= pat_q | {N_LED{!(pwm_q < BRIGHT)}};
            pulse_dly_q <= pulse_q;
        end
    end

    assign LED_OUT    = out_q;
    assign STEP_PULSE = pulse_dly_q;
`else
    assign LED_OUT    = pat_q;
    assign STEP_PULSE = pulse_q;
`endif

endmodule
